ds_frame_arbiter: RTL

- Shares one downsample channel (16-bit ready/valid, WIDTH x HEIGHT raster in, every even-x/even-y pixel out) between NUM_REQ source streams.
- Grants are whole frames, assigned round-robin. The block passes the granted source into the channel and forwards the channel output to a single sink, tagged with the source id.
- The grant is held until the channel has emitted the complete decimated frame. Pixels from two frames never interleave.

---
 rtl/ds_arb_pkg.sv | 30 +++
 rtl/ds_frame_arbiter_rr_pick.sv | 39 +++
 rtl/ds_frame_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ds_arb_pkg.sv
// Shared types and sizing helpers for the downsample-channel frame arbiter.
package ds_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS  = 2'b01,
    DRAIN = 2'b10
  } arb_state_e;

  // Input beats in one full-resolution frame.
  function automatic int in_beats(input int width, input int height);
    return width * height;
  endfunction

  // Output beats in one decimated frame (every even-x / even-y pixel).
  function automatic int out_beats(input int width, input int height);
    return (width / 2) * (height / 2);
  endfunction

  // Counter width for a counter that runs 0..limit-1; never narrower than 1 bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  // Width of a requester id.
  function automatic int id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/ds_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last+1 with wrap-around. Usable by any shared-resource arbiter.
module ds_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic               hit,
  output logic [IDW-1:0]     id
);

  logic           lo_hit;
  logic [IDW-1:0] lo_id;
  logic           hi_hit;
  logic [IDW-1:0] hi_id;

  // Lowest requester overall, and lowest requester strictly above last;
  // the latter wins, the former is the wrap-around fallback.
  always_comb begin
    lo_hit = 1'b0;
    lo_id  = '0;
    hi_hit = 1'b0;
    hi_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_hit = 1'b1;
        lo_id  = IDW'(i);
        if (IDW'(i) > last) begin
          hi_hit = 1'b1;
          hi_id  = IDW'(i);
        end
      end
    end
    hit = lo_hit;
    id  = hi_hit ? hi_id : lo_id;
  end

endmodule

// File: rtl/ds_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one downsample channel between
// NUM_REQ sources. Optional per-source frame counters: DS_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no frame owned; picking next source round-robin
// PASS  | granted source streams into the channel, channel output to sink
// DRAIN | all input beats taken; waiting for final decimated output beat
module ds_frame_arbiter
  import ds_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int WIDTH   = 32,
  parameter int HEIGHT  = 32,
  localparam int IDW    = id_w(NUM_REQ)
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [NUM_REQ-1:0]        src_valid,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  output logic [NUM_REQ-1:0]        src_ready,
  output logic                      ch_in_valid,
  output logic [DATA_W-1:0]         ch_in_data,
  input  logic                      ch_in_ready,
  input  logic                      ch_out_valid,
  input  logic [DATA_W-1:0]         ch_out_data,
  output logic                      ch_out_ready,
  output logic                      dst_valid,
  output logic [DATA_W-1:0]         dst_data,
  output logic [IDW-1:0]            dst_id,
  output logic                      dst_last,
  input  logic                      dst_ready,
  output logic                      busy
`ifdef DS_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     frames_done
`endif
);

  localparam int IN_BEATS  = in_beats(WIDTH, HEIGHT);
  localparam int OUT_BEATS = out_beats(WIDTH, HEIGHT);
  localparam int IN_CW     = cnt_w(IN_BEATS);
  localparam int OUT_CW    = cnt_w(OUT_BEATS);
  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_BEATS - 1);
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BEATS - 1);

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;
  logic              out_done_q, out_done_d;

  logic              pick_hit;
  logic [IDW-1:0]    pick_id;
  logic              in_fire;
  logic              out_last;

  ds_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req  (src_valid),
    .last (last_grant_q),
    .hit  (pick_hit),
    .id   (pick_id)
  );

  // Next-state, counters and all combinational pass-through paths.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    out_done_d   = out_done_q;
    src_ready    = '0;
    ch_in_valid  = 1'b0;
    ch_in_data   = '0;
    ch_out_ready = 1'b0;
    dst_valid    = 1'b0;
    dst_data     = '0;
    dst_id       = '0;
    dst_last     = 1'b0;
    in_fire      = 1'b0;
    out_last     = 1'b0;

    // Output path is live for the whole owned frame. The final decimated
    // pixel can leave the channel before the last raster pixel enters it,
    // so out_done remembers that and keeps out_cnt from running past the end.
    if (state_q != IDLE) begin
      dst_valid    = ch_out_valid;
      dst_data     = ch_out_data;
      ch_out_ready = dst_ready;
      dst_id       = grant_q;
      dst_last     = ch_out_valid & (out_cnt_q == OUT_LAST) & ~out_done_q;
      out_last     = dst_last & dst_ready;
      if (ch_out_valid && dst_ready && (out_cnt_q != OUT_LAST)) begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
      if (out_last) begin
        out_done_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_d    = pick_id;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          out_done_d = 1'b0;
          state_d    = PASS;
        end
      end
      PASS: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == IDW'(i)) begin
            ch_in_valid  = src_valid[i];
            ch_in_data   = src_data[i*DATA_W +: DATA_W];
            src_ready[i] = ch_in_ready;
          end
        end
        in_fire = ch_in_valid & ch_in_ready;
        if (in_fire) begin
          if (in_cnt_q == IN_LAST) begin
            if (out_last || out_done_q) begin
              last_grant_d = grant_q;
              state_d      = IDLE;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // State and counter registers; last_grant resets to the top id so source 0 wins first.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      out_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      out_done_q   <= out_done_d;
    end
  end

`ifdef DS_ARB_STATS_EN
  logic [15:0] frames_q [NUM_REQ];
  logic [15:0] frames_d [NUM_REQ];

  // Per-source completed-frame count, bumped on that source's last output beat.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      frames_d[i] = frames_q[i];
      if (out_last && (grant_q == IDW'(i))) begin
        frames_d[i] = frames_q[i] + 16'd1;
      end
    end
  end

  // Frame counter registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        frames_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        frames_q[i] <= frames_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_frames
    assign frames_done[g*16 +: 16] = frames_q[g];
  end
`endif

endmodule
